// File: rtl/ssb_pkg.sv
// Shared types for the system-bus arbiter: request/response bundles,
// performance counter record, host and target enumerations.
package ssb_pkg;

    localparam int NumHosts = 3;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } ssb_req_t;

    typedef struct packed {
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
    } ssb_rsp_t;

    typedef struct packed {
        logic [31:0] dbg_gnt_cnt;
        logic [31:0] instr_gnt_cnt;
        logic [31:0] data_gnt_cnt;
        logic [31:0] starve_cyc_cnt;
    } ssb_perf_t;

    // Host index doubles as the bit position in grant/owner vectors.
    typedef enum logic [1:0] {
        HostDbg   = 2'd0,
        HostInstr = 2'd1,
        HostData  = 2'd2
    } host_e;

    typedef enum logic [1:0] {
        TgtSram = 2'd0,
        TgtDm   = 2'd1,
        TgtNone = 2'd2
    } tgt_e;

endpackage

// File: rtl/ssb_addr_decode.sv
// Pure combinational decode of a bus address to SRAM, debug memory or
// nothing. SRAM wins if the two windows overlap.
module ssb_addr_decode
    import ssb_pkg::*;
#(
    parameter logic [31:0] MemStart = 32'h0000_0000,
    parameter logic [31:0] MemMask  = 32'h0000_FFFF,
    parameter logic [31:0] DmStart  = 32'h1A11_0000,
    parameter logic [31:0] DmMask   = 32'h0000_FFFF
) (
    input  logic [31:0] addr,
    output tgt_e        target
);

    // Window compare; the SRAM check is evaluated last so it takes precedence.
    always_comb begin
        target = TgtNone;
        if ((addr & ~DmMask) == DmStart) begin
            target = TgtDm;
        end
        if ((addr & ~MemMask) == MemStart) begin
            target = TgtSram;
        end
    end

endmodule

// File: rtl/ssb_arbiter.sv
// Shared system bus arbiter for debug SBA, Ibex instr and Ibex data ports.
// Combinational single grant per cycle, one-cycle response routed back to
// the owning host, starvation protection for the data port, error response
// for unmapped addresses.
// Optional: define SSB_ARB_PERF_EN to build the grant/starvation counters
// on perf_o; otherwise perf_o is tied to zero.
module ssb_arbiter
    import ssb_pkg::*;
#(
    parameter logic [31:0] MemStart    = 32'h0000_0000,
    parameter logic [31:0] MemMask     = 32'h0000_FFFF,
    parameter logic [31:0] DmStart     = 32'h1A11_0000,
    parameter logic [31:0] DmMask      = 32'h0000_FFFF,
    parameter int unsigned StarveLimit = 8
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  ssb_req_t    dbg_req_i,
    output logic        dbg_gnt_o,
    output ssb_rsp_t    dbg_rsp_o,
    input  ssb_req_t    instr_req_i,
    output logic        instr_gnt_o,
    output ssb_rsp_t    instr_rsp_o,
    input  ssb_req_t    data_req_i,
    output logic        data_gnt_o,
    output ssb_rsp_t    data_rsp_o,
    output ssb_req_t    ssb_o,
    output logic        sram_req_o,
    output logic        dm_req_o,
    input  logic [31:0] sram_rdata_i,
    input  logic [31:0] dm_rdata_i,
    output ssb_perf_t   perf_o
);

    localparam logic [7:0] StarveMax = 8'(StarveLimit);

    ssb_req_t            req_arr [NumHosts];
    ssb_rsp_t            rsp_arr [NumHosts];
    logic [NumHosts-1:0] gnt;
    ssb_req_t            bus;
    tgt_e                bus_tgt;
    logic [NumHosts-1:0] owner_reg;
    tgt_e                target_reg;
    logic [7:0]          starve_cnt_reg;
    logic [7:0]          starve_cnt_next;
    logic                starved;
    logic [31:0]         rsp_rdata;
    logic                unused_instr_fields;

    // Instruction fetches are always full-word reads; their write fields are dropped.
    assign req_arr[HostDbg]   = dbg_req_i;
    assign req_arr[HostInstr] = '{req: instr_req_i.req, addr: instr_req_i.addr,
                                  we: 1'b0, be: 4'hF, wdata: 32'h0};
    assign req_arr[HostData]  = data_req_i;
    assign unused_instr_fields = ^{instr_req_i.we, instr_req_i.be, instr_req_i.wdata};

    assign starved = (starve_cnt_reg == StarveMax);

    // Fixed priority dbg > instr > data, with data lifted above instr once starved.
    always_comb begin
        gnt = '0;
        if (rst_sys_n) begin
            if (req_arr[HostDbg].req) begin
                gnt[HostDbg] = 1'b1;
            end else if (starved && req_arr[HostData].req) begin
                gnt[HostData] = 1'b1;
            end else if (req_arr[HostInstr].req) begin
                gnt[HostInstr] = 1'b1;
            end else if (req_arr[HostData].req) begin
                gnt[HostData] = 1'b1;
            end
        end
    end

    // Forward the granted host's command; an idle bus is all zero.
    always_comb begin
        bus = '0;
        for (int i = 0; i < NumHosts; i++) begin
            if (gnt[i]) begin
                bus = req_arr[i];
            end
        end
    end

    ssb_addr_decode #(
        .MemStart (MemStart),
        .MemMask  (MemMask),
        .DmStart  (DmStart),
        .DmMask   (DmMask)
    ) u_decode (
        .addr   (bus.addr),
        .target (bus_tgt)
    );

    assign dbg_gnt_o   = gnt[HostDbg];
    assign instr_gnt_o = gnt[HostInstr];
    assign data_gnt_o  = gnt[HostData];
    assign ssb_o       = bus;
    assign sram_req_o  = bus.req && (bus_tgt == TgtSram);
    assign dm_req_o    = bus.req && (bus_tgt == TgtDm);

    // Data-port starvation counter: counts denied cycles, saturates, clears on grant or idle.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!data_req_i.req || gnt[HostData]) begin
            starve_cnt_next = 8'd0;
        end else if (starve_cnt_reg != StarveMax) begin
            starve_cnt_next = starve_cnt_reg + 8'd1;
        end
    end

    // Capture who owns next cycle's response and where it comes from.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            owner_reg      <= '0;
            target_reg     <= TgtNone;
            starve_cnt_reg <= 8'd0;
        end else begin
            owner_reg      <= gnt;
            target_reg     <= bus_tgt;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // Select response data from the registered target; unmapped returns zero.
    always_comb begin
        case (target_reg)
            TgtSram: rsp_rdata = sram_rdata_i;
            TgtDm:   rsp_rdata = dm_rdata_i;
            default: rsp_rdata = 32'h0;
        endcase
    end

    // Only the owning host sees rvalid/err/rdata; everyone else sees zeros.
    generate
        for (genvar gi = 0; gi < NumHosts; gi++) begin : g_rsp
            assign rsp_arr[gi] = '{rvalid: owner_reg[gi],
                                   err:    owner_reg[gi] && (target_reg == TgtNone),
                                   rdata:  owner_reg[gi] ? rsp_rdata : 32'h0};
        end
    endgenerate

    assign dbg_rsp_o   = rsp_arr[HostDbg];
    assign instr_rsp_o = rsp_arr[HostInstr];
    assign data_rsp_o  = rsp_arr[HostData];

`ifdef SSB_ARB_PERF_EN
    ssb_perf_t perf_reg;

    // Wrapping grant counters per host plus a count of starved cycles.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            perf_reg <= '0;
        end else begin
            if (gnt[HostDbg]) begin
                perf_reg.dbg_gnt_cnt <= perf_reg.dbg_gnt_cnt + 32'd1;
            end
            if (gnt[HostInstr]) begin
                perf_reg.instr_gnt_cnt <= perf_reg.instr_gnt_cnt + 32'd1;
            end
            if (gnt[HostData]) begin
                perf_reg.data_gnt_cnt <= perf_reg.data_gnt_cnt + 32'd1;
            end
            if (starved) begin
                perf_reg.starve_cyc_cnt <= perf_reg.starve_cyc_cnt + 32'd1;
            end
        end
    end

    assign perf_o = perf_reg;
`else
    assign perf_o = '0;
`endif

endmodule

// File: tb/tb_ssb_arbiter.sv
// Self-checking bench for ssb_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_ssb_arbiter;
    import ssb_pkg::*;

    localparam int LIMIT = 8;

    logic        clk_sys;
    logic        rst_sys_n;
    ssb_req_t    dbg_req, instr_req, data_req, ssb_bus;
    ssb_rsp_t    dbg_rsp, instr_rsp, data_rsp;
    logic        dbg_gnt, instr_gnt, data_gnt, sram_req, dm_req;
    logic [31:0] sram_rdata, dm_rdata;
    ssb_perf_t   perf;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          m_owner;
    int          m_tgt;
    int          m_starve;
    int unsigned m_perf [4];

    ssb_arbiter dut (
        .clk_sys      (clk_sys),
        .rst_sys_n    (rst_sys_n),
        .dbg_req_i    (dbg_req),
        .dbg_gnt_o    (dbg_gnt),
        .dbg_rsp_o    (dbg_rsp),
        .instr_req_i  (instr_req),
        .instr_gnt_o  (instr_gnt),
        .instr_rsp_o  (instr_rsp),
        .data_req_i   (data_req),
        .data_gnt_o   (data_gnt),
        .data_rsp_o   (data_rsp),
        .ssb_o        (ssb_bus),
        .sram_req_o   (sram_req),
        .dm_req_o     (dm_req),
        .sram_rdata_i (sram_rdata),
        .dm_rdata_i   (dm_rdata),
        .perf_o       (perf)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Winner from the priority rules: dbg first, data before instr only when starved.
    function automatic int pick(bit d, bit i, bit a, int starve);
        if (d) return 0;
        if (a && starve == LIMIT) return 1 + 1;
        if (i) return 1;
        if (a) return 2;
        return -1;
    endfunction

    // 0 = SRAM, 1 = debug memory, 2 = unmapped
    function automatic int region(logic [31:0] addr);
        if ((addr & 32'hFFFF_0000) == 32'h0000_0000) return 0;
        if ((addr & 32'hFFFF_0000) == 32'h1A11_0000) return 1;
        return 2;
    endfunction

    function automatic ssb_req_t rand_req(int pct);
        ssb_req_t r;
        int k;
        r.req = ($urandom_range(99) < pct);
        k = $urandom_range(2);
        case (k)
            0:       r.addr = $urandom & 32'h0000_FFFF;
            1:       r.addr = 32'h1A11_0000 | ($urandom & 32'h0000_FFFF);
            default: r.addr = $urandom;
        endcase
        r.we    = 1'($urandom);
        r.be    = 4'($urandom);
        r.wdata = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        rst_sys_n  = 1'b0;
        dbg_req    = '0;
        instr_req  = '0;
        data_req   = '0;
        sram_rdata = 32'h0;
        dm_rdata   = 32'h0;
        repeat (2) @(posedge clk_sys);
        #1 rst_sys_n = 1'b1;
        m_owner  = -1;
        m_tgt    = 2;
        m_starve = 0;
        for (int i = 0; i < 4; i++) m_perf[i] = 0;
    endtask

    task automatic test_reset();
        rst_sys_n = 1'b0;
        dbg_req   = '{req: 1'b1, addr: 32'h10, we: 1'b1, be: 4'hF, wdata: 32'h1};
        instr_req = '{req: 1'b1, addr: 32'h20, we: 1'b0, be: 4'hF, wdata: 32'h0};
        data_req  = '{req: 1'b1, addr: 32'h30, we: 1'b0, be: 4'hF, wdata: 32'h0};
        sram_rdata = 32'h1234_5678;
        dm_rdata   = 32'h8765_4321;
        #14;
        n_cmp++;
        if ({dbg_gnt, instr_gnt, data_gnt, sram_req, dm_req} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_gnt: got %b required 00000", {dbg_gnt, instr_gnt, data_gnt, sram_req, dm_req});
        end
        n_cmp++;
        if (ssb_bus !== '0) begin
            n_bad++;
            $display("FAIL reset_bus: got %h required 0", ssb_bus);
        end
        n_cmp++;
        if ({dbg_rsp, instr_rsp, data_rsp} !== '0 || perf !== '0) begin
            n_bad++;
            $display("FAIL reset_rsp_perf: got rsp %h perf %h required 0", {dbg_rsp, instr_rsp, data_rsp}, perf);
        end
        $display("test_reset: outputs sampled under reset");
    endtask

    task automatic test_instr_read();
        do_reset();
        instr_req  = '{req: 1'b1, addr: 32'h100, we: 1'b0, be: 4'hF, wdata: 32'h0};
        sram_rdata = 32'hDEAD_BEEF;
        #4;
        n_cmp++;
        if ({dbg_gnt, instr_gnt, data_gnt, sram_req, dm_req} !== 5'b01010) begin
            n_bad++;
            $display("FAIL instr_gnt: got %b required 01010", {dbg_gnt, instr_gnt, data_gnt, sram_req, dm_req});
        end
        n_cmp++;
        if ({ssb_bus.req, ssb_bus.addr, ssb_bus.we, ssb_bus.be} !== {1'b1, 32'h100, 1'b0, 4'hF}) begin
            n_bad++;
            $display("FAIL instr_bus: got %h required addr 100", ssb_bus);
        end
        tick();
        instr_req = '0;
        #4;
        n_cmp++;
        if (instr_rsp !== '{rvalid: 1'b1, err: 1'b0, rdata: 32'hDEAD_BEEF} || dbg_rsp !== '0 || data_rsp !== '0) begin
            n_bad++;
            $display("FAIL instr_rsp: got %h/%h/%h required 0/%h/0", dbg_rsp, instr_rsp, data_rsp, {2'b10, 32'hDEAD_BEEF});
        end
        $display("test_instr_read: addr 0x100 rdata %h", instr_rsp.rdata);
        tick();
    endtask

    task automatic test_priority();
        do_reset();
        dbg_req    = '{req: 1'b1, addr: 32'h1A11_0004, we: 1'b0, be: 4'hF, wdata: 32'h0};
        instr_req  = '{req: 1'b1, addr: 32'h0000_0008, we: 1'b0, be: 4'hF, wdata: 32'h0};
        data_req   = '{req: 1'b1, addr: 32'h0000_0010, we: 1'b0, be: 4'hF, wdata: 32'h0};
        sram_rdata = 32'hAAAA_0001;
        dm_rdata   = 32'hBBBB_0002;
        #4;
        n_cmp++;
        if ({dbg_gnt, instr_gnt, data_gnt, sram_req, dm_req} !== 5'b10001) begin
            n_bad++;
            $display("FAIL prio_dbg: got %b required 10001", {dbg_gnt, instr_gnt, data_gnt, sram_req, dm_req});
        end
        tick();
        dbg_req = '0;
        #4;
        n_cmp++;
        if ({dbg_gnt, instr_gnt, data_gnt} !== 3'b010 || dbg_rsp !== '{rvalid: 1'b1, err: 1'b0, rdata: 32'hBBBB_0002}) begin
            n_bad++;
            $display("FAIL prio_instr: got gnt %b dbg_rsp %h required 010 / %h", {dbg_gnt, instr_gnt, data_gnt}, dbg_rsp, {2'b10, 32'hBBBB_0002});
        end
        tick();
        instr_req = '0;
        #4;
        n_cmp++;
        if ({dbg_gnt, instr_gnt, data_gnt} !== 3'b001 || instr_rsp !== '{rvalid: 1'b1, err: 1'b0, rdata: 32'hAAAA_0001}) begin
            n_bad++;
            $display("FAIL prio_data: got gnt %b instr_rsp %h required 001 / %h", {dbg_gnt, instr_gnt, data_gnt}, instr_rsp, {2'b10, 32'hAAAA_0001});
        end
        tick();
        data_req = '0;
        #4;
        n_cmp++;
        if (data_rsp !== '{rvalid: 1'b1, err: 1'b0, rdata: 32'hAAAA_0001} || {dbg_gnt, instr_gnt, data_gnt} !== 3'b000) begin
            n_bad++;
            $display("FAIL prio_data_rsp: got %h gnt %b required %h / 000", data_rsp, {dbg_gnt, instr_gnt, data_gnt}, {2'b10, 32'hAAAA_0001});
        end
        $display("test_priority: dbg, instr, data granted in turn");
        tick();
    endtask

    task automatic test_starvation();
        logic [2:0] eg;
        do_reset();
        instr_req = '{req: 1'b1, addr: 32'h0000_0200, we: 1'b0, be: 4'hF, wdata: 32'h0};
        data_req  = '{req: 1'b1, addr: 32'h0000_0300, we: 1'b0, be: 4'hF, wdata: 32'h0};
        for (int c = 1; c <= 10; c++) begin
            #4;
            eg = (c == 9) ? 3'b001 : 3'b010;
            n_cmp++;
            if ({dbg_gnt, instr_gnt, data_gnt} !== eg) begin
                n_bad++;
                $display("FAIL starve_cycle%0d: got %b required %b", c, {dbg_gnt, instr_gnt, data_gnt}, eg);
            end
            $display("test_starvation: cycle %0d gnt %b", c, {dbg_gnt, instr_gnt, data_gnt});
            tick();
        end
`ifdef SSB_ARB_PERF_EN
        n_cmp++;
        if (perf !== '{dbg_gnt_cnt: 32'd0, instr_gnt_cnt: 32'd9, data_gnt_cnt: 32'd1, starve_cyc_cnt: 32'd1}) begin
            n_bad++;
            $display("FAIL starve_perf: got %h required 0/9/1/1", perf);
        end
`endif
        instr_req = '0;
        data_req  = '0;
        tick();
    endtask

    task automatic test_unmapped();
        do_reset();
        data_req   = '{req: 1'b1, addr: 32'h2000_0000, we: 1'b1, be: 4'h3, wdata: 32'h0000_CAFE};
        sram_rdata = 32'h5555_5555;
        dm_rdata   = 32'h6666_6666;
        #4;
        n_cmp++;
        if ({dbg_gnt, instr_gnt, data_gnt, sram_req, dm_req} !== 5'b00100) begin
            n_bad++;
            $display("FAIL unmapped_gnt: got %b required 00100", {dbg_gnt, instr_gnt, data_gnt, sram_req, dm_req});
        end
        n_cmp++;
        if (ssb_bus !== '{req: 1'b1, addr: 32'h2000_0000, we: 1'b1, be: 4'h3, wdata: 32'h0000_CAFE}) begin
            n_bad++;
            $display("FAIL unmapped_bus: got %h required write 20000000", ssb_bus);
        end
        tick();
        data_req = '0;
        #4;
        n_cmp++;
        if (data_rsp !== '{rvalid: 1'b1, err: 1'b1, rdata: 32'h0}) begin
            n_bad++;
            $display("FAIL unmapped_rsp: got %h required %h", data_rsp, {2'b11, 32'h0});
        end
        $display("test_unmapped: write 0x20000000 err %b", data_rsp.err);
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        sram_rdata = 32'h1111_1111;
        dm_rdata   = 32'h2222_2222;
        instr_req  = '{req: 1'b1, addr: 32'h0, we: 1'b0, be: 4'hF, wdata: 32'h0};
        #4;
        n_cmp++;
        if ({instr_gnt, sram_req} !== 2'b11) begin
            n_bad++;
            $display("FAIL b2b_instr_gnt: got %b required 11", {instr_gnt, sram_req});
        end
        tick();
        instr_req = '0;
        data_req  = '{req: 1'b1, addr: 32'h1A11_0800, we: 1'b0, be: 4'hF, wdata: 32'h0};
        #4;
        n_cmp++;
        if ({data_gnt, sram_req, dm_req} !== 3'b101 || instr_rsp !== '{rvalid: 1'b1, err: 1'b0, rdata: 32'h1111_1111} || data_rsp !== '0) begin
            n_bad++;
            $display("FAIL b2b_overlap: got gnt/sel %b instr_rsp %h data_rsp %h", {data_gnt, sram_req, dm_req}, instr_rsp, data_rsp);
        end
        tick();
        data_req = '0;
        #4;
        n_cmp++;
        if (data_rsp !== '{rvalid: 1'b1, err: 1'b0, rdata: 32'h2222_2222} || instr_rsp !== '0) begin
            n_bad++;
            $display("FAIL b2b_data_rsp: got %h instr %h required %h / 0", data_rsp, instr_rsp, {2'b10, 32'h2222_2222});
        end
        $display("test_back_to_back: instr then dm data response %h", data_rsp.rdata);
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        instr_req  = '{req: 1'b1, addr: 32'h40, we: 1'b0, be: 4'hF, wdata: 32'h0};
        sram_rdata = 32'h7777_7777;
        tick();
        rst_sys_n = 1'b0;
        dbg_req   = '{req: 1'b1, addr: 32'h44, we: 1'b0, be: 4'hF, wdata: 32'h0};
        data_req  = '{req: 1'b1, addr: 32'h48, we: 1'b0, be: 4'hF, wdata: 32'h0};
        #4;
        n_cmp++;
        if ({dbg_gnt, instr_gnt, data_gnt, sram_req, dm_req} !== 5'b0 || ssb_bus !== '0
            || {dbg_rsp, instr_rsp, data_rsp} !== '0 || perf !== '0) begin
            n_bad++;
            $display("FAIL midrst_outputs: gnt/sel %b bus %h instr_rsp %h perf %h required all 0",
                     {dbg_gnt, instr_gnt, data_gnt, sram_req, dm_req}, ssb_bus, instr_rsp, perf);
        end
        tick();
        tick();
        rst_sys_n = 1'b1;
        dbg_req   = '0;
        instr_req = '0;
        data_req  = '0;
        for (int c = 0; c < 2; c++) begin
            #4;
            n_cmp++;
            if ({dbg_rsp, instr_rsp, data_rsp} !== '0) begin
                n_bad++;
                $display("FAIL midrst_no_rvalid%0d: got %h required 0", c, {dbg_rsp, instr_rsp, data_rsp});
            end
            tick();
        end
        $display("test_reset_mid: pending response discarded");
    endtask

    task automatic test_random();
        int         w;
        ssb_req_t   hr  [3];
        ssb_rsp_t   act [3];
        ssb_rsp_t   ex;
        ssb_req_t   eb;
        logic [2:0] eg;
        logic [1:0] es;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            dbg_req    = rand_req(15);
            instr_req  = rand_req(80);
            data_req   = rand_req(70);
            sram_rdata = $urandom;
            dm_rdata   = $urandom;
            hr[0] = dbg_req;
            hr[1] = instr_req;
            hr[2] = data_req;
            w = pick(dbg_req.req, instr_req.req, data_req.req, m_starve);
            #4;
            eg = (w < 0) ? 3'b000 : (3'b100 >> w);
            n_cmp++;
            if ({dbg_gnt, instr_gnt, data_gnt} !== eg) begin
                n_bad++;
                $display("FAIL rnd_gnt c%0d: got %b required %b", c, {dbg_gnt, instr_gnt, data_gnt}, eg);
            end
            eb = '0;
            es = 2'b00;
            if (w >= 0) begin
                eb = hr[w];
                if (w == 1) begin
                    eb.we = 1'b0;
                    eb.be = 4'hF;
                end
                es = (region(eb.addr) == 0) ? 2'b10 : (region(eb.addr) == 1) ? 2'b01 : 2'b00;
            end
            n_cmp++;
            if ({ssb_bus.req, ssb_bus.addr, ssb_bus.we, ssb_bus.be, sram_req, dm_req} !==
                {eb.req, eb.addr, eb.we, eb.be, es}) begin
                n_bad++;
                $display("FAIL rnd_bus c%0d: got %h sel %b required %h sel %b", c, ssb_bus, {sram_req, dm_req}, eb, es);
            end
            if (w == 0 || w == 2) begin
                n_cmp++;
                if (ssb_bus.wdata !== eb.wdata) begin
                    n_bad++;
                    $display("FAIL rnd_wdata c%0d: got %h required %h", c, ssb_bus.wdata, eb.wdata);
                end
            end
            act[0] = dbg_rsp;
            act[1] = instr_rsp;
            act[2] = data_rsp;
            for (int h = 0; h < 3; h++) begin
                ex = '0;
                if (m_owner == h) begin
                    ex.rvalid = 1'b1;
                    ex.err    = (m_tgt == 2);
                    ex.rdata  = (m_tgt == 0) ? sram_rdata : (m_tgt == 1) ? dm_rdata : 32'h0;
                end
                n_cmp++;
                if (act[h] !== ex) begin
                    n_bad++;
                    $display("FAIL rnd_rsp c%0d host%0d: got %h required %h", c, h, act[h], ex);
                end
            end
            $display("txn %0d: winner %0d addr %h starve %0d", c, w, eb.addr, m_starve);
            if (m_starve == LIMIT) m_perf[3]++;
            if (w >= 0) m_perf[w]++;
            if (!data_req.req || w == 2) m_starve = 0;
            else if (m_starve < LIMIT) m_starve++;
            if (w >= 0) begin
                m_owner = w;
                m_tgt   = region(hr[w].addr);
            end else begin
                m_owner = -1;
            end
            tick();
        end
        n_cmp++;
`ifdef SSB_ARB_PERF_EN
        if (perf !== {m_perf[0], m_perf[1], m_perf[2], m_perf[3]}) begin
            n_bad++;
            $display("FAIL rnd_perf: got %h required %h", perf, {m_perf[0], m_perf[1], m_perf[2], m_perf[3]});
        end
`else
        if (perf !== '0) begin
            n_bad++;
            $display("FAIL rnd_perf: got %h required 0", perf);
        end
`endif
        dbg_req   = '0;
        instr_req = '0;
        data_req  = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_instr_read();
        test_priority();
        test_starvation();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
